// File: rtl/toothless_pkg.sv
// Core-wide shared types; this slice carries the M-extension additions.
package toothless_pkg;

   localparam logic [6:0] OPC_R_TYPE   = 7'b011_0011;
   localparam logic [6:0] OPC_M_FUNCT7 = 7'b000_0001;

   // Encoded exactly as instruction funct3
   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_opcode_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIXUP,
      DONE
   } md_state_e;

endpackage

// File: rtl/toothless_muldiv_ctrl.sv
// Sequencing for the iterative mul/div unit: FSM, iteration counter and both handshakes.
module toothless_muldiv_ctrl
   import toothless_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      valid_i,
   input  logic      kill_i,
   input  logic      ready_i,
   input  logic      early_i,
   output logic      ready_o,
   output logic      valid_o,
   output logic      busy_o,
   output md_state_e state_o,
   output logic      accept_c
);

   localparam int unsigned CW = $clog2(XLEN);

   md_state_e         state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   assign accept_c = (state_q == IDLE) && valid_i && !kill_i;
   assign state_o  = state_q;

   // Next state; kill overrides every transition, including a DONE handshake
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               cnt_d   = '0;
               state_d = early_i ? DONE : CALC;
            end
         end
         CALC: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN - 1)) state_d = FIXUP;
         end
         FIXUP:   state_d = DONE;
         DONE:    if (ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (kill_i) state_d = IDLE;
   end

   // Status outputs are registered copies decoded from the next state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ready_o <= 1'b1;
         valid_o <= 1'b0;
         busy_o  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_o <= (state_d == IDLE);
         valid_o <= (state_d == DONE);
         busy_o  <= (state_d != IDLE);
      end
   end

endmodule

// File: rtl/toothless_muldiv.sv
// Radix-2 iterative RV32M/RV64M multiply/divide unit beside the execute-stage ALU.
module toothless_muldiv
   import toothless_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter bit          EARLY_OUT = 1'b1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            kill_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);

   localparam int unsigned PW = 2 * XLEN;

   md_opcode_e      op_c, op_q;
   md_state_e       state;
   logic            accept_c;
   logic            a_sign_c, b_sign_c, b_zero_c, ovf_c, special_c, neg_c, neg_q;
   logic [XLEN-1:0] abs_a_c, abs_b_c, special_res_c, opb_q, result_q;
   logic [PW-1:0]   prod_q, prod_neg_c;
   logic [XLEN:0]   rem_q, mul_sum_c;
   logic [XLEN+1:0] div_shift_c, div_diff_c;
   logic            q_bit_c;
   logic [XLEN-1:0] quo_c, rmd_c, fix_res_c;

   assign op_c = md_opcode_e'(op_i);

   // Operand decode at acceptance: signs, magnitudes, special cases
   always_comb begin
      a_sign_c = a_i[XLEN-1] & (op_c inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
      b_sign_c = b_i[XLEN-1] & (op_c inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
      abs_a_c  = a_sign_c ? -a_i : a_i;
      abs_b_c  = b_sign_c ? -b_i : b_i;
      b_zero_c = (b_i == '0);
      ovf_c    = (op_c inside {MD_DIV, MD_REM}) && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&b_i);
      special_c = op_i[2] && (b_zero_c || ovf_c);
      if (b_zero_c) special_res_c = op_i[1] ? a_i : '1;
      else          special_res_c = op_i[1] ? '0  : a_i;
      // Divide by zero keeps an all-ones quotient magnitude unnegated
      if (!op_i[2])     neg_c = a_sign_c ^ b_sign_c;
      else if (op_i[1]) neg_c = a_sign_c;
      else              neg_c = (a_sign_c ^ b_sign_c) & !b_zero_c;
   end

   toothless_muldiv_ctrl #(
      .XLEN (XLEN)
   ) u_ctrl (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .valid_i  (valid_i),
      .kill_i   (kill_i),
      .ready_i  (ready_i),
      .early_i  (EARLY_OUT & special_c),
      .ready_o  (ready_o),
      .valid_o  (valid_o),
      .busy_o   (busy_o),
      .state_o  (state),
      .accept_c (accept_c)
   );

   // One shift-add or restore-subtract step, plus the fixup result select
   always_comb begin
      mul_sum_c   = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
      div_shift_c = {rem_q, prod_q[XLEN-1]};
      div_diff_c  = div_shift_c - {2'b00, opb_q};
      q_bit_c     = !div_diff_c[XLEN+1];
      prod_neg_c  = neg_q ? -prod_q : prod_q;
      quo_c       = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
      rmd_c       = neg_q ? -rem_q[XLEN-1:0]  : rem_q[XLEN-1:0];
      if (op_q == MD_MUL)  fix_res_c = prod_neg_c[XLEN-1:0];
      else if (!op_q[2])   fix_res_c = prod_neg_c[PW-1:XLEN];
      else if (op_q[1])    fix_res_c = rmd_c;
      else                 fix_res_c = quo_c;
   end

   // Datapath registers; the low product half doubles as dividend/quotient
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_q     <= MD_MUL;
         neg_q    <= 1'b0;
         opb_q    <= '0;
         prod_q   <= '0;
         rem_q    <= '0;
         result_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_c) begin
                  op_q   <= op_c;
                  neg_q  <= neg_c;
                  opb_q  <= abs_b_c;
                  prod_q <= {{XLEN{1'b0}}, abs_a_c};
                  rem_q  <= '0;
                  if (EARLY_OUT && special_c) result_q <= special_res_c;
               end
            end
            CALC: begin
               if (op_q[2]) begin
                  rem_q  <= q_bit_c ? div_diff_c[XLEN:0] : div_shift_c[XLEN:0];
                  prod_q <= {prod_q[PW-1:XLEN], prod_q[XLEN-2:0], q_bit_c};
               end else begin
                  prod_q <= {mul_sum_c, prod_q[XLEN-1:1]};
               end
            end
            FIXUP:   result_q <= fix_res_c;
            default: ;
         endcase
      end
   end

   assign result_o = result_q;

endmodule
